// File: rtl/sram_mmio_responder_pkg.sv
// Shared constants and helpers for the SRAM-port responder: MMIO decode
// values, register offsets and the byte-strobe merge.
package sram_mmio_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = 8;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned SW_W   = 8;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

  localparam logic [OFF_W-1:0] OFF_LED    = 8'h00;
  localparam logic [OFF_W-1:0] OFF_SWITCH = 8'h04;
  localparam logic [OFF_W-1:0] OFF_TIMER  = 8'h08;
  localparam logic [OFF_W-1:0] OFF_NUM    = 8'h0C;

  // Replace the lanes of old_word selected by we with the matching lanes of wdata.
  function automatic logic [DATA_W-1:0] strobe_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] wdata,
    input logic [STRB_W-1:0] we
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_bytelane_ram.sv
// Word RAM with per-byte write enables and a registered read port.
// Contents are never cleared; reset only zeroes the read register and
// blocks a write that lands on an edge while reset is high.
module sram_bytelane_ram
  import sram_mmio_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      if (rd_en) rdata <= mem[addr];
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_mmio_responder.sv
// Responder for the CPU's single-cycle SRAM data port: byte-writable RAM
// plus LED / switch / timer / display registers, one-cycle read latency.
module sram_mmio_responder
  import sram_mmio_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sram_en,
  input  logic [STRB_W-1:0] sram_we,
  input  logic [31:0]       sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DATA_W-1:0] num_data
);

  logic              is_mmio;
  logic              is_write;
  logic [OFF_W-1:0]  offset;
  logic              mmio_wr;
  logic              mmio_rd;
  logic              ram_rd;
  logic [STRB_W-1:0] ram_we;

  logic [SW_W-1:0]   switch_meta;
  logic [SW_W-1:0]   switch_sync;
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] led_merged;
  logic [DATA_W-1:0] mmio_rdata_c;
  logic [DATA_W-1:0] mmio_q;
  logic [DATA_W-1:0] ram_q;
  logic              sel_ram;

  // Address decode; the byte offset inside a word is ignored everywhere.
  assign is_mmio  = (sram_addr[31:16] == MMIO_HI);
  assign is_write = |sram_we;
  assign offset   = {sram_addr[OFF_W-1:2], 2'b00};
  assign mmio_wr  = sram_en && is_mmio && is_write;
  assign mmio_rd  = sram_en && is_mmio && !is_write;
  assign ram_rd   = sram_en && !is_mmio && !is_write;
  assign ram_we   = (sram_en && !is_mmio) ? sram_we : '0;

  assign led_merged = strobe_merge({16'b0, led}, sram_wdata, sram_we);

  logic unused_bits;
  assign unused_bits = ^{sram_addr, led_merged[DATA_W-1:LED_W]};

  sram_bytelane_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (ram_rd),
    .we    (ram_we),
    .addr  (sram_addr[ADDR_W+1:2]),
    .wdata (sram_wdata),
    .rdata (ram_q)
  );

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      switch_meta <= '0;
      switch_sync <= '0;
    end else begin
      switch_meta <= switch;
      switch_sync <= switch_meta;
    end
  end

  // Free-running timer; a write replaces the increment for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (mmio_wr && offset == OFF_TIMER) begin
      timer <= strobe_merge(timer, sram_wdata, sram_we);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led      <= '0;
      num_data <= '0;
    end else if (mmio_wr) begin
      if (offset == OFF_LED) led <= led_merged[LED_W-1:0];
      if (offset == OFF_NUM) num_data <= strobe_merge(num_data, sram_wdata, sram_we);
    end
  end

  always_comb begin
    mmio_rdata_c = '0;
    case (offset)
      OFF_LED:    mmio_rdata_c = {16'b0, led};
      OFF_SWITCH: mmio_rdata_c = {24'b0, switch_sync};
      OFF_TIMER:  mmio_rdata_c = timer;
      OFF_NUM:    mmio_rdata_c = num_data;
      default:    mmio_rdata_c = '0;
    endcase
  end

  // Read source select; both sources hold their value on non-read cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_q  <= '0;
      sel_ram <= 1'b0;
    end else if (mmio_rd) begin
      mmio_q  <= mmio_rdata_c;
      sel_ram <= 1'b0;
    end else if (ram_rd) begin
      sel_ram <= 1'b1;
    end
  end

  assign sram_rdata = sel_ram ? ram_q : mmio_q;

endmodule

// File: tb/tb_sram_mmio_responder.sv
// Directed bench for sram_mmio_responder: RAM strobes, MMIO registers,
// timer wrap, switch synchronizer latency and asynchronous reset.
module tb_sram_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_mmio_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .switch     (switch),
    .led        (led),
    .num_data   (num_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each call occupies one clock cycle, starting at the falling edge.
  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = a;
    sram_wdata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    drive(1'b1, we, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; sram_en = 1'b0; sram_we = 4'h0;
    sram_addr = '0; sram_wdata = '0; switch = 8'h00;
    idle();
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_num", num_data, 32'h0);
    reset = 1'b0;
    idle();

    // Full-word RAM write, then read-after-write
    wr(32'h1C000010, 32'h12345678, 4'hF);
    rd(32'h1C000010);
    idle();
    check("ram_full_word", sram_rdata, 32'h12345678);

    // Single-lane write
    wr(32'h1C000010, 32'hAABBCCDD, 4'b0010);
    check("rdata_hold_on_write", sram_rdata, 32'h12345678);
    rd(32'h1C000010);
    idle();
    check("ram_lane1", sram_rdata, 32'h1234CC78);
    check("rdata_hold_when_idle", sram_rdata, 32'h1234CC78);

    // Aliasing: upper word-index bits are ignored
    rd(32'h1C004010);
    idle();
    check("ram_alias", sram_rdata, 32'h1234CC78);

    // LED register
    wr(32'hBFAF0000, 32'hFFFF00F0, 4'hF);
    rd(32'hBFAF0000);
    check("led_out", 32'(led), 32'h000000F0);
    rd(32'hBFAF0040);
    check("led_readback", sram_rdata, 32'h000000F0);
    idle();
    check("unmapped_read", sram_rdata, 32'h0);

    // Timer load and count, then wrap
    wr(32'hBFAF0008, 32'h00000100, 4'hF);
    idle();
    idle();
    rd(32'hBFAF0008);
    idle();
    check("timer_count", sram_rdata, 32'h00000102);
    wr(32'hBFAF0008, 32'hFFFFFFFF, 4'hF);
    idle();
    rd(32'hBFAF0008);
    idle();
    check("timer_wrap", sram_rdata, 32'h00000000);

    // Switch synchronizer: same-cycle read sees old value, +2 sees new
    rd(32'hBFAF0004);
    switch = 8'hA5;
    idle();
    check("switch_old", sram_rdata, 32'h00000000);
    rd(32'hBFAF0004);
    idle();
    check("switch_new", sram_rdata, 32'h000000A5);
    wr(32'hBFAF0004, 32'hFFFFFFFF, 4'hF);
    rd(32'hBFAF0004);
    idle();
    check("switch_ro", sram_rdata, 32'h000000A5);

    // NUM register with full and partial strobes; unmapped write ignored
    wr(32'hBFAF000C, 32'hDEADBEEF, 4'hF);
    wr(32'hBFAF000C, 32'h11000000, 4'b1000);
    check("num_full", num_data, 32'hDEADBEEF);
    wr(32'hBFAF0010, 32'h55555555, 4'hF);
    check("num_lane3", num_data, 32'h11ADBEEF);
    rd(32'hBFAF0010);
    idle();
    check("unmapped_write", sram_rdata, 32'h0);
    rd(32'hBFAF000C);
    idle();
    check("num_readback", sram_rdata, 32'h11ADBEEF);

    // Asynchronous reset in the middle of a write stream
    wr(32'h1C002000, 32'hCAFEF00D, 4'hF);
    wr(32'hBFAF0000, 32'h00001234, 4'hF);
    wr(32'hBFAF000C, 32'h00000777, 4'hF);
    rd(32'h1C002000);
    wr(32'hBFAF000C, 32'h00000999, 4'hF);
    check("pre_reset_rdata", sram_rdata, 32'hCAFEF00D);
    check("pre_reset_led", 32'(led), 32'h00001234);
    #1 reset = 1'b1;
    #1;
    check("async_rdata", sram_rdata, 32'h0);
    check("async_led", 32'(led), 32'h0);
    check("async_num", num_data, 32'h0);
    idle();
    reset = 1'b0;
    check("dropped_write", num_data, 32'h0);
    rd(32'h1C002000);
    idle();
    check("ram_kept", sram_rdata, 32'hCAFEF00D);
    rd(32'hBFAF000C);
    idle();
    check("num_after_reset", sram_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
